// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//
// Purpose:
//   N_CH:1 stream multiplexer with a single registered output stage. The
//   producer channels use valid/ready handshakes, and so does the consumer.
//   Arbitration is round-robin (RR_MODE=1) or fixed priority with the lowest
//   index winning (RR_MODE=0). A forced select can restrict eligibility to a
//   single channel. Each output word is tagged with its source channel.
//
// Parameters:
//   N_CH    - number of input channels (>= 2)
//   WIDTH   - data width per channel
//   RR_MODE - 1 = round-robin, 0 = fixed priority (lowest index first)
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - asynchronous active-high reset
//   in_valid     - per-channel valid
//   in_data      - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready     - per-channel ready, one-hot or zero (combinational)
//   sel_force_en - when set, only channel sel_force is eligible
//   sel_force    - forced channel index
//   out_valid    - output register holds a word
//   out_data     - registered data of the granted channel
//   out_ch       - source channel of out_data
//   out_ready    - consumer accepts the word in the output register
// -----------------------------------------------------------------------------
module stream_mux_rr #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 4,
  parameter int RR_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           in_valid,
  input  logic [N_CH*WIDTH-1:0]     in_data,
  output logic [N_CH-1:0]           in_ready,
  input  logic                      sel_force_en,
  input  logic [$clog2(N_CH)-1:0]   sel_force,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  input  logic                      out_ready
);

  localparam int CW = $clog2(N_CH);

  logic [N_CH-1:0]  eligible_s;
  logic [CW-1:0]    start_s;
  logic             grant_valid_s;
  logic [CW-1:0]    grant_idx_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             load_en_s;
  logic [CW-1:0]    ptr_next_s;
  logic [CW-1:0]    ptr_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CW-1:0]    out_ch_r;
  int               idx_s;

  // Register accepts a new word when empty or drained this cycle; nothing is
  // accepted while reset is asserted.
  always_comb begin
    load_en_s = (!rst) && ((!out_valid_r) || out_ready);
  end

  // Eligible channels: valid, and matching the forced index when forcing.
  // An out-of-range forced index matches no channel.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_force_en) begin
        eligible_s[i] = in_valid[i] && (sel_force == CW'(i));
      end else begin
        eligible_s[i] = in_valid[i];
      end
    end
  end

  // Search start: the round-robin pointer, or channel 0 in fixed mode.
  always_comb begin
    if (RR_MODE != 0) begin
      start_s = ptr_r;
    end else begin
      start_s = '0;
    end
  end

  // First eligible channel from start_s upward, wrapping past N_CH-1.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    idx_s         = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx_s = (int'(start_s) + k) % N_CH;
      if (!grant_valid_s && eligible_s[idx_s]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = CW'(idx_s);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Granted channel's data only; other channels' slices are never selected,
  // so unknown data on them cannot reach the output register.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx_s == CW'(i)) begin
        sel_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Ready goes to the granted channel only, and only when the register loads.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = load_en_s && grant_valid_s && (grant_idx_s == CW'(i));
    end
  end

  // Pointer moves one past the granted channel, wrapping to 0.
  always_comb begin
    if (grant_idx_s == CW'(N_CH - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + CW'(1);
    end
  end

  // Output register: load on grant, empty when nothing is granted, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
    end else if (load_en_s) begin
      if (grant_valid_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data_s;
        out_ch_r    <= grant_idx_s;
      end else begin
        out_valid_r <= 1'b0;
        out_data_r  <= out_data_r;
        out_ch_r    <= out_ch_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_ch_r    <= out_ch_r;
    end
  end

  // Round-robin pointer advances on every input transfer, forced or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if ((RR_MODE != 0) && load_en_s && grant_valid_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic        sel_force_en;
  logic [1:0]  sel_force;
  logic        out_ready;

  logic [3:0]  rr_in_ready;
  logic        rr_out_valid;
  logic [3:0]  rr_out_data;
  logic [1:0]  rr_out_ch;

  logic [3:0]  fp_in_ready;
  logic        fp_out_valid;
  logic [3:0]  fp_out_data;
  logic [1:0]  fp_out_ch;

  int checks;
  int errors;

  stream_mux_rr #(.N_CH(4), .WIDTH(4), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .sel_force_en(sel_force_en), .sel_force(sel_force),
    .out_valid(rr_out_valid), .out_data(rr_out_data), .out_ch(rr_out_ch),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(4), .WIDTH(4), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .sel_force_en(sel_force_en), .sel_force(sel_force),
    .out_valid(fp_out_valid), .out_data(fp_out_data), .out_ch(fp_out_ch),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rr(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, {31'd0, rr_out_valid}, {31'd0, v});
    chk({tag, "_data"},  {28'd0, rr_out_data},  {28'd0, d});
    chk({tag, "_ch"},    {30'd0, rr_out_ch},    {30'd0, c});
  endtask

  initial begin
    logic [3:0] exp_d [0:8];
    logic [1:0] exp_c [0:8];
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    in_valid     = 4'b0000;
    in_data      = 16'hDCBA;
    sel_force_en = 1'b0;
    sel_force    = 2'd0;
    out_ready    = 1'b1;
    exp_d = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    #1;
    chk_rr("por", 1'b0, 4'h0, 2'd0);
    chk("por_ready", {28'd0, rr_in_ready}, 32'h0);
    step();
    step();
    rst = 1'b0;

    // Single channel: ch2 alone.
    in_valid = 4'b0100;
    #1;
    chk("single_ready", {28'd0, rr_in_ready}, 32'h4);
    step();
    chk_rr("single", 1'b1, 4'hC, 2'd2);

    // ptr now 3: ch1 alone is granted after wrap, giving a held word 'hB.
    in_valid = 4'b0010;
    step();
    chk_rr("hold_b", 1'b1, 4'hB, 2'd1);
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    step();
    chk_rr("stall_b", 1'b1, 4'hB, 2'd1);

    // Asynchronous reset mid-cycle while the word is held.
    #2;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    chk_rr("async_rst", 1'b0, 4'h0, 2'd0);
    chk("rst_ready", {28'd0, rr_in_ready}, 32'h0);
    chk("rst_ready_fp", {28'd0, fp_in_ready}, 32'h0);
    step();
    chk_rr("rst_edge", 1'b0, 4'h0, 2'd0);
    rst = 1'b0;
    #1;
    chk("first_grant_ch0", {28'd0, rr_in_ready}, 32'h1);

    // Round-robin fairness, one word per cycle.
    for (int k = 0; k < 9; k++) begin
      step();
      chk_rr($sformatf("rr%0d", k), 1'b1, exp_d[k], exp_c[k]);
    end
    chk_rr("fp_steady", fp_out_valid, fp_out_data, fp_out_ch);
    chk("fp_ch0_data", {28'd0, fp_out_data}, 32'hA);
    chk("fp_ch0_ch", {30'd0, fp_out_ch}, 32'h0);

    // Backpressure for three cycles while 'hA is held.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready%0d", k), {28'd0, rr_in_ready}, 32'h0);
      step();
      chk_rr($sformatf("bp%0d", k), 1'b1, 4'hA, 2'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {28'd0, rr_in_ready}, 32'h2);
    chk("fp_release_ready", {28'd0, fp_in_ready}, 32'h1);
    step();
    chk_rr("bp_next", 1'b1, 4'hB, 2'd1);
    chk("fp_still_ch0", {30'd0, fp_out_ch}, 32'h0);
    chk("fp_still_a", {28'd0, fp_out_data}, 32'hA);

    // Fixed priority: drop ch0, ch1 wins.
    in_valid = 4'b1110;
    #1;
    chk("fp_drop0_ready", {28'd0, fp_in_ready}, 32'h2);
    chk("rr_drop0_ready", {28'd0, rr_in_ready}, 32'h4);
    step();
    chk("fp_drop0_ch", {30'd0, fp_out_ch}, 32'h1);
    chk("fp_drop0_data", {28'd0, fp_out_data}, 32'hB);
    chk_rr("rr_drop0", 1'b1, 4'hC, 2'd2);

    // Forced select of ch3 while only ch0..2 are valid; ch3 data unknown.
    sel_force_en = 1'b1;
    sel_force    = 2'd3;
    in_valid     = 4'b0111;
    in_data      = {4'bxxxx, 4'h3, 4'hA, 4'h7};
    #1;
    chk("force_ready", {28'd0, rr_in_ready}, 32'h0);
    chk("force_ready_fp", {28'd0, fp_in_ready}, 32'h0);
    step();
    chk("force_empty", {31'd0, rr_out_valid}, 32'h0);
    chk("force_nox0", {31'd0, $isunknown(rr_out_data)}, 32'h0);
    chk("force_hold_data", {28'd0, rr_out_data}, 32'hC);
    in_valid = 4'b1111;
    in_data  = {4'hD, 4'h3, 4'hA, 4'h7};
    #1;
    chk("force3_ready", {28'd0, rr_in_ready}, 32'h8);
    step();
    chk_rr("force3", 1'b1, 4'hD, 2'd3);
    chk("force3_fp_ch", {30'd0, fp_out_ch}, 32'h3);
    chk("force_nox1", {31'd0, $isunknown(rr_out_data)}, 32'h0);

    // Release forcing: ptr wrapped to 0, order resumes from ch0.
    sel_force_en = 1'b0;
    in_data      = 16'hDCBA;
    #1;
    chk("resume_ready", {28'd0, rr_in_ready}, 32'h1);
    step();
    chk_rr("resume0", 1'b1, 4'hA, 2'd0);
    step();
    chk_rr("resume1", 1'b1, 4'hB, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer with registered output and valid/ready handshakes on every input and on the output.
- Arbitrates between N_CH producer channels using round-robin or fixed-priority mode. An optional forced-select input overrides arbitration.
- Tags each output word with its source channel number.
- Sits between several producers and a single consumer. Successor to the combinational 2:1/4:1 select muxes.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 4, data width per channel in bits.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, N_CH, per-channel valid.
- in_data, input, N_CH*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready, output, N_CH, per-channel ready; at most one bit set.
- sel_force_en, input, 1, 1 = only channel sel_force is eligible.
- sel_force, input, $clog2(N_CH), forced channel index.
- out_valid, output, 1, output register holds a word.
- out_data, output, WIDTH, registered selected data.
- out_ch, output, $clog2(N_CH), source channel of out_data.
- out_ready, input, 1, consumer accepts.

Behaviour:
- Reset (asynchronous, any cycle): out_valid=0, out_data=0, out_ch=0, round-robin pointer=0 (channel 0 highest priority). A word held at reset is dropped.
- Transfers: an input transfer occurs when in_valid[i] & in_ready[i]. An output transfer occurs when out_valid & out_ready.
- load_en = !out_valid | out_ready. The register accepts a new word when it is empty or being drained in the same cycle. This gives full throughput of 1 word/cycle.
- Eligible set:
  - sel_force_en=0: eligible = in_valid.
  - sel_force_en=1: eligible = in_valid & onehot(sel_force).
  - sel_force >= N_CH (non-power-of-2 N_CH): no channel is eligible.
- Grant selection:
  - RR_MODE=1: first eligible channel searching from ptr upward, with wrap-around from N_CH-1 to 0.
  - RR_MODE=0: lowest-index eligible channel.
- in_ready[g] = load_en & (grant exists) for the granted channel g; all other bits are 0. in_ready is combinational from out_ready, in_valid, sel_force_en and sel_force. A producer must not make in_valid depend on in_ready.
- Output register update at posedge, when load_en and a grant exists: out_valid<=1, out_data<=in_data[g], out_ch<=g.
- When load_en and no grant exists: out_valid<=0; out_data and out_ch hold their values.
- When !load_en: all output registers hold.
- Latency: 1 cycle from an accepted input to out_valid.
- Round-robin pointer:
  - Updates only on an actual input transfer: ptr <= (g+1) mod N_CH.
  - Not updated by forced grants? No — forced grants also advance ptr.
  - Unchanged in fixed mode and during stalls.
- Starvation freedom: in RR_MODE=1 with continuous out_ready, a continuously valid channel is granted within N_CH cycles.
- Data isolation: in_data of non-granted channels, including X, must never affect out_data.
- Stability: while out_valid=1 and out_ready=0, out_data and out_ch must not change.
- No combinational path from in_data to any output.

Test Plan (N_CH=4, WIDTH=4, RR_MODE=1 unless stated):
1. Reset: rst=1 mid-stream with out_valid=1 and data 'hB -> immediately out_valid=0, out_data=0, out_ch=0, in_ready=0000. After release, the first grant with all channels valid goes to ch0.
2. Single channel: in_valid=0100, ch2 data 'hC, out_ready=1 -> in_ready=0100 in that cycle. Next cycle out_valid=1, out_data='hC, out_ch=2.
3. Round-robin fairness: in_valid=1111 held, data 'hA,'hB,'hC,'hD on ch0..3, out_ready=1 -> out_data sequence A,B,C,D,A,B with out_ch 0,1,2,3,0,1. One word per cycle, no bubbles.
4. Backpressure: while out_valid=1 and out_data='hA, hold out_ready=0 for 3 cycles -> out_data stays 'hA and in_ready=0000. The cycle out_ready returns to 1, in_ready=0010 and the next word is 'hB.
5. Fixed priority: RR_MODE=0, in_valid=1111, out_ready=1 -> ch0 granted every cycle, out_ch=0 and out_data='hA throughout. Drop in_valid[0] -> ch1 is granted.
6. Forced select with X isolation:
   - Setup: sel_force_en=1, sel_force=3; ch0..2 valid with data 7, 10, 3; ch3 data 'x and invalid.
   - Expected: in_ready=0000 and out_valid falls to 0.
   - Then ch3 goes valid with data 'hD -> out_data='hD, out_ch=3, with no X on out_data at any time.
   - Then sel_force_en=0 with ptr=0 -> grant order resumes from ch0.
